// File: rtl/frame_lock_ctrl.sv
// ---------------------------------------------------------------------------
// frame_lock_ctrl
//
// Lock controller for the 32-bit frame synchronizer / descrambler path of the
// ETROC2 receive chain. It watches the 2-bit frame header produced by the
// frame aligner and does the following:
// - While hunting, it issues single-cycle bitslip requests until the headers
//   become stable.
// - Once enough consecutive good headers arrive, it declares lock and
//   reseeds/enables the descrambler.
// - While locked, it counts bad headers in fixed-size windows and drops lock
//   when the error density gets too high.
//
// Ports:
//   CLK             in   system clock, everything on the rising edge
//   RST             in   synchronous reset, active-high
//   header_in       in   [1:0] frame header, 01/10 = good, 00/11 = bad
//   header_valid    in   header_in qualifies this cycle
//   force_resync    in   slow-control request to restart acquisition
//   bitslip         out  one-cycle pulse, shift frame boundary by one bit
//   locked          out  frame lock achieved
//   descr_enable    out  descrambler output enable (same as locked)
//   descr_rst       out  one-cycle descrambler reseed pulse on lock entry
//   slip_pos        out  [4:0] bitslips issued so far, modulo 32
//   hunt_timeout    out  sticky, a full 32-slip sweep went by without lock
//   lock_loss_count out  [CNT_W-1:0] number of LOCKED exits, saturating
//   err_count       out  [CNT_W-1:0] bad headers seen while LOCKED, saturating
//   state_out       out  [2:0] current state encoding
// ---------------------------------------------------------------------------
module frame_lock_ctrl #(
  parameter int SLIP_WAIT  = 4,
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 16,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       header_in,
  input  logic             header_valid,
  input  logic             force_resync,
  output logic             bitslip,
  output logic             locked,
  output logic             descr_enable,
  output logic             descr_rst,
  output logic [4:0]       slip_pos,
  output logic             hunt_timeout,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  // Counter widths are sized so each counter can hold its own terminal value.
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(UNLOCK_ERR + 1);
  localparam int TW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] LOCK_TARGET   = GW'(LOCK_COUNT);
  localparam logic [WW-1:0] WINDOW_TARGET = WW'(WINDOW);
  localparam logic [BW-1:0] UNLOCK_TARGET = BW'(UNLOCK_ERR);
  localparam logic [TW-1:0] WAIT_LAST     = TW'(SLIP_WAIT - 1);
  localparam bit            DIRECT_LOCK   = (LOCK_COUNT <= 1);

  state_t           r_state;
  logic [GW-1:0]    r_goodCnt;
  logic [WW-1:0]    r_winCnt;
  logic [BW-1:0]    r_badCnt;
  logic [TW-1:0]    r_waitCnt;
  logic [4:0]       r_slipPos;
  logic             r_huntTimeout;
  logic [CNT_W-1:0] r_lockLoss;
  logic [CNT_W-1:0] r_errCnt;
  logic             r_descrRst;

  state_t           w_stateNext;
  logic [GW-1:0]    w_goodCntNext;
  logic [WW-1:0]    w_winCntNext;
  logic [BW-1:0]    w_badCntNext;
  logic [TW-1:0]    w_waitCntNext;
  logic [4:0]       w_slipPosNext;
  logic             w_huntTimeoutNext;
  logic [CNT_W-1:0] w_lockLossNext;
  logic [CNT_W-1:0] w_errCntNext;
  logic             w_descrRstNext;

  logic             w_headerGood;
  logic [GW-1:0]    w_goodInc;
  logic [WW-1:0]    w_winInc;
  logic [BW-1:0]    w_badInc;
  logic [CNT_W-1:0] w_lockLossInc;
  logic [CNT_W-1:0] w_errCntInc;

  // A header is good when its two bits differ (01 or 10).
  assign w_headerGood  = header_in[0] ^ header_in[1];
  assign w_goodInc     = r_goodCnt + 1'b1;
  assign w_winInc      = r_winCnt + 1'b1;
  assign w_badInc      = r_badCnt + 1'b1;
  assign w_lockLossInc = (r_lockLoss == '1) ? r_lockLoss : r_lockLoss + 1'b1;
  assign w_errCntInc   = (r_errCnt == '1) ? r_errCnt : r_errCnt + 1'b1;

  // State register and all counters. Reset is synchronous and wins over
  // everything, so a mid-operation RST looks exactly like power-up reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_goodCnt     <= '0;
      r_winCnt      <= '0;
      r_badCnt      <= '0;
      r_waitCnt     <= '0;
      r_slipPos     <= '0;
      r_huntTimeout <= 1'b0;
      r_lockLoss    <= '0;
      r_errCnt      <= '0;
      r_descrRst    <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_goodCnt     <= w_goodCntNext;
      r_winCnt      <= w_winCntNext;
      r_badCnt      <= w_badCntNext;
      r_waitCnt     <= w_waitCntNext;
      r_slipPos     <= w_slipPosNext;
      r_huntTimeout <= w_huntTimeoutNext;
      r_lockLoss    <= w_lockLossNext;
      r_errCnt      <= w_errCntNext;
      r_descrRst    <= w_descrRstNext;
    end
  end

  // Next-state and next-counter logic. The per-state case handles normal
  // sequencing; force_resync is applied afterwards so it overrides any state
  // decision, and lock entry side effects are applied last based on the
  // resolved next state.
  always_comb begin
    w_stateNext       = r_state;
    w_goodCntNext     = r_goodCnt;
    w_winCntNext      = r_winCnt;
    w_badCntNext      = r_badCnt;
    w_waitCntNext     = r_waitCnt;
    w_slipPosNext     = r_slipPos;
    w_huntTimeoutNext = r_huntTimeout;
    w_lockLossNext    = r_lockLoss;
    w_errCntNext      = r_errCnt;
    w_descrRstNext    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stateNext = ST_HUNT;
      end

      ST_HUNT: begin
        if (header_valid) begin
          if (w_headerGood) begin
            w_goodCntNext = GW'(1);
            w_stateNext   = DIRECT_LOCK ? ST_LOCKED : ST_VERIFY;
          end else begin
            w_stateNext = ST_SLIP;
          end
        end
      end

      // The bitslip pulse is this state itself; the position is advanced as
      // the state is left, and a full wrap marks the hunt as timed out.
      ST_SLIP: begin
        w_slipPosNext = r_slipPos + 5'd1;
        if (r_slipPos == 5'd31) begin
          w_huntTimeoutNext = 1'b1;
        end
        w_waitCntNext = '0;
        w_stateNext   = ST_WAIT;
      end

      // Headers are ignored here; the aligner needs time to settle after a
      // slip before its output is meaningful again.
      ST_WAIT: begin
        if (r_waitCnt == WAIT_LAST) begin
          w_stateNext = ST_HUNT;
        end else begin
          w_waitCntNext = r_waitCnt + 1'b1;
        end
      end

      ST_VERIFY: begin
        if (header_valid) begin
          if (w_headerGood) begin
            w_goodCntNext = w_goodInc;
            if (w_goodInc == LOCK_TARGET) begin
              w_stateNext = ST_LOCKED;
            end
          end else begin
            w_goodCntNext = '0;
            w_stateNext   = ST_SLIP;
          end
        end
      end

      // Unlock is checked with the current sample included and takes
      // precedence over a window boundary on the same sample.
      ST_LOCKED: begin
        if (header_valid) begin
          w_winCntNext = w_winInc;
          if (!w_headerGood) begin
            w_badCntNext = w_badInc;
            w_errCntNext = w_errCntInc;
          end
          if (!w_headerGood && (w_badInc == UNLOCK_TARGET)) begin
            w_stateNext    = ST_HUNT;
            w_lockLossNext = w_lockLossInc;
          end else if (w_winInc == WINDOW_TARGET) begin
            w_winCntNext = '0;
            w_badCntNext = '0;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    // A resync discards the current sample's evaluation. A slip already
    // pulsing this cycle still counts toward slip_pos because the aligner
    // has physically shifted; it simply is not issued again.
    if (force_resync) begin
      w_stateNext    = ST_HUNT;
      w_goodCntNext  = '0;
      w_winCntNext   = '0;
      w_badCntNext   = '0;
      w_waitCntNext  = '0;
      w_errCntNext   = r_errCnt;
      w_lockLossNext = (r_state == ST_LOCKED) ? w_lockLossInc : r_lockLoss;
    end

    if ((w_stateNext == ST_LOCKED) && (r_state != ST_LOCKED)) begin
      w_descrRstNext    = 1'b1;
      w_huntTimeoutNext = 1'b0;
      w_winCntNext      = '0;
      w_badCntNext      = '0;
    end
  end

  assign bitslip         = (r_state == ST_SLIP);
  assign locked          = (r_state == ST_LOCKED);
  assign descr_enable    = locked;
  assign descr_rst       = r_descrRst;
  assign slip_pos        = r_slipPos;
  assign hunt_timeout    = r_huntTimeout;
  assign lock_loss_count = r_lockLoss;
  assign err_count       = r_errCnt;
  assign state_out       = r_state;

endmodule

// File: tb/tb_frame_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_lock_ctrl
//
// Directed bench for frame_lock_ctrl with default parameters. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so every applyStimulus call covers exactly one clock edge.
// ---------------------------------------------------------------------------
module tb_frame_lock_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  header_in;
  logic        header_valid;
  logic        force_resync;
  logic        bitslip;
  logic        locked;
  logic        descr_enable;
  logic        descr_rst;
  logic [4:0]  slip_pos;
  logic        hunt_timeout;
  logic [15:0] lock_loss_count;
  logic [15:0] err_count;
  logic [2:0]  state_out;

  int testCount = 0;
  int failCount = 0;

  frame_lock_ctrl dut (
    .CLK             (CLK),
    .RST             (RST),
    .header_in       (header_in),
    .header_valid    (header_valid),
    .force_resync    (force_resync),
    .bitslip         (bitslip),
    .locked          (locked),
    .descr_enable    (descr_enable),
    .descr_rst       (descr_rst),
    .slip_pos        (slip_pos),
    .hunt_timeout    (hunt_timeout),
    .lock_loss_count (lock_loss_count),
    .err_count       (err_count),
    .state_out       (state_out)
  );

  // 10-unit clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive the inputs for the coming edge, then step past it.
  task automatic applyStimulus(input logic [1:0] hdr, input logic vld,
                               input logic frc, input logic rst);
    header_in    = hdr;
    header_valid = vld;
    force_resync = frc;
    RST          = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Single directed sequence covering reset, acquisition, error windows,
  // unlock, resync, mid-run reset and the hunt timeout.
  initial begin
    int slipSeen;
    int earlyLock;
    int pulses;
    int backToBack;
    int cycles;
    int timeoutDrop;
    logic prevSlip;

    header_in    = 2'b00;
    header_valid = 1'b0;
    force_resync = 1'b0;
    RST          = 1'b1;

    // Reset state
    repeat (3) applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_state", state_out, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_bitslip", bitslip, 0);
    checkOutput("rst_descr_rst", descr_rst, 0);
    checkOutput("rst_slip_pos", slip_pos, 0);
    checkOutput("rst_loss", lock_loss_count, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_timeout", hunt_timeout, 0);

    // Constant good header: IDLE after reset, edge 1 -> HUNT, edge 2 HUNT
    // sample, edges 3..65 VERIFY samples, so locked appears after edge 65.
    slipSeen  = 0;
    earlyLock = 0;
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
      if (bitslip) slipSeen++;
      if (locked) earlyLock++;
      if (k == 1) checkOutput("acq_hunt_after_idle", state_out, 1);
    end
    checkOutput("acq_no_bitslip", slipSeen, 0);
    checkOutput("acq_not_early", earlyLock, 0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("acq_locked", locked, 1);
    checkOutput("acq_descr_en", descr_enable, 1);
    checkOutput("acq_descr_rst", descr_rst, 1);
    checkOutput("acq_state", state_out, 5);
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("acq_descr_rst_fall", descr_rst, 0);
    checkOutput("acq_still_locked", locked, 1);

    // Three windows of 64 samples, 15 bad each: lock holds.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) begin
        applyStimulus((i < 15) ? 2'b00 : 2'b01, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("win_locked", locked, 1);
      checkOutput("win_err", err_count, 15 * (w + 1));
    end
    checkOutput("win_err_total", err_count, 45);

    // Sixteenth bad header within one window drops lock.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      if (i == 14) checkOutput("unlock_15_held", locked, 1);
    end
    checkOutput("unlock_state", state_out, 1);
    checkOutput("unlock_locked", locked, 0);
    checkOutput("unlock_loss", lock_loss_count, 1);
    checkOutput("unlock_err", err_count, 61);

    // Bad headers from HUNT: pulses on cycles 1,7,13,19; slip_pos counts
    // the pulses that have already completed.
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      checkOutput("slip_pulse", bitslip, ((c % 6) == 1) ? 1 : 0);
      checkOutput("slip_pos_track", slip_pos, (c + 4) / 6);
    end
    // Good from now: WAIT 20..23, HUNT 24, sample at 25, lock after 88.
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("slip_pos_4", slip_pos, 4);
    checkOutput("slip_wait_state", state_out, 3);
    for (int c = 21; c <= 87; c++) applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("relock_not_yet", locked, 0);
    checkOutput("relock_verify", state_out, 4);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("relock_locked", locked, 1);
    checkOutput("relock_descr_rst", descr_rst, 1);

    // force_resync while locked
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b0);
    checkOutput("frc_lock_state", state_out, 1);
    checkOutput("frc_lock_locked", locked, 0);
    checkOutput("frc_lock_loss", lock_loss_count, 2);
    checkOutput("frc_lock_slip_pos", slip_pos, 4);

    // force_resync while in WAIT
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("frc_wait_slip", bitslip, 1);
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("frc_wait_in_wait", state_out, 3);
    checkOutput("frc_wait_pos5", slip_pos, 5);
    applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
    checkOutput("frc_wait_state", state_out, 1);
    checkOutput("frc_wait_loss", lock_loss_count, 2);
    checkOutput("frc_wait_slip_pos", slip_pos, 5);
    checkOutput("frc_wait_no_slip", bitslip, 0);

    // Reset in the middle of VERIFY
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_verify_state", state_out, 4);
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
    checkOutput("mid_rst_state", state_out, 0);
    checkOutput("mid_rst_locked", locked, 0);
    checkOutput("mid_rst_slip_pos", slip_pos, 0);
    checkOutput("mid_rst_loss", lock_loss_count, 0);
    checkOutput("mid_rst_err", err_count, 0);
    checkOutput("mid_rst_bitslip", bitslip, 0);

    // All-bad for 200 cycles: pulses after edges 2+6k; the 32nd pulse is on
    // edge 188 and slip_pos wraps to 0 after edge 189.
    pulses     = 0;
    backToBack = 0;
    prevSlip   = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
      if (bitslip) pulses++;
      if (bitslip && prevSlip) backToBack++;
      prevSlip = bitslip;
      if (e == 188) begin
        checkOutput("wrap_pulse32", bitslip, 1);
        checkOutput("wrap_pos31", slip_pos, 31);
        checkOutput("wrap_timeout_pre", hunt_timeout, 0);
      end
      if (e == 189) begin
        checkOutput("wrap_pos0", slip_pos, 0);
        checkOutput("wrap_timeout_set", hunt_timeout, 1);
      end
    end
    checkOutput("wrap_pulses", pulses, 34);
    checkOutput("wrap_back_to_back", backToBack, 0);
    checkOutput("wrap_timeout_sticky", hunt_timeout, 1);
    checkOutput("wrap_final_pos", slip_pos, 1);

    // Lock after the timeout clears it: 69 edges from the last slip.
    cycles      = 0;
    timeoutDrop = 0;
    while (!locked && cycles < 100) begin
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
      cycles++;
      if (!locked && !hunt_timeout) timeoutDrop++;
    end
    checkOutput("tmo_lock_cycles", cycles, 69);
    checkOutput("tmo_locked", locked, 1);
    checkOutput("tmo_held_until_lock", timeoutDrop, 0);
    checkOutput("tmo_cleared", hunt_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
